// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receiver and the future transmitter:
// receiver state encoding, oversampling constants, the baud divisor
// calculation and the 3-sample majority vote.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
// Byte-side handshake between the UART receiver and its consumer.
//   rx_data      received byte
//   rx_avail     rx_data valid, held until rx_ack
//   rx_ack       consumer strobe, one cycle
//   rx_frame_err one-cycle pulse on a low stop bit
//   rx_overrun   sticky, a byte was dropped
// master: the receiver. slave: the consumer.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_ack;
    logic       rx_frame_err;
    logic       rx_overrun;

    modport master (
        output rx_data,
        output rx_avail,
        output rx_frame_err,
        output rx_overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_avail,
        input  rx_frame_err,
        input  rx_overrun,
        output rx_ack
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Free-running divider producing the oversample tick.
//   clk   system clock
//   rst   asynchronous active-high reset, count returns to 0
//   tick  one-cycle strobe every DIV cycles, high while count = DIV-1
module uart_baud_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_baud_gen: DIV must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 serial receiver, 16x oversampled with a 3-sample majority vote
// around the middle of each bit. Holds each byte until acknowledged,
// flags low stop bits and dropped bytes.
//   clk       system clock
//   rst       asynchronous active-high reset
//   uart_rxd  serial line, idle high, asynchronous to clk
//   bus       byte-side handshake (uart_rx_if.master)
//
// state     | meaning
// IDLE      | line idle, waiting for rxs low
// START     | validating the start bit at mid-bit
// DATA      | sampling 8 data bits, LSB first
// STOP      | sampling the stop bit
// WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 115200
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      uart_rxd,
    uart_rx_if.master bus
);

    localparam int DIV = calc_div(clk_freq, uart_baud_rate);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [TW-1:0] SAMP_FIRST = TW'(MID_TICK - 1);
    localparam logic [TW-1:0] SAMP_MID   = TW'(MID_TICK);
    localparam logic [TW-1:0] SAMP_LAST  = TW'(MID_TICK + 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_rx: clk_freq too low for uart_baud_rate (DIV < 2)");
        end
    endgenerate

    uart_state_t          state, state_nx;
    logic                 rxd_meta, rxs;
    logic                 tick;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bidx;
    logic [1:0]           samp;
    logic [DATA_BITS-1:0] shreg;
    logic [7:0]           data_r;
    logic                 avail_r, ovr_r, ferr_r;

    logic decide, bit_val;
    logic tcnt_clr, bidx_clr, shift_en, byte_done, ferr_set;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxs      <= rxd_meta;
        end
    end

    // samp holds the samples from ticks 6 and 7; the live rxs supplies
    // the third vote at tick 8, so the decision lands on that tick.
    assign decide  = tick && (tcnt == SAMP_LAST);
    assign bit_val = majority3(samp[1], samp[0], rxs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tcnt_clr  = 1'b0;
        bidx_clr  = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        ferr_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nx = START;
                    tcnt_clr = 1'b1;
                end
            end
            START: begin
                if (decide) begin
                    if (bit_val) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = DATA;
                        bidx_clr = 1'b1;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bidx == LAST_BIT) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                // Leave STOP at mid-bit so a start edge right after the
                // stop bit is not missed.
                if (decide) begin
                    if (bit_val) begin
                        byte_done = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_nx = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // tcnt wraps modulo 16, so the decision tick of each following bit
    // comes exactly one bit period after the previous one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt  <= '0;
            bidx  <= '0;
            samp  <= 2'b11;
            shreg <= '0;
        end else begin
            if (tcnt_clr) begin
                tcnt <= '0;
            end else if (tick) begin
                tcnt <= tcnt + 1'b1;
            end
            if (tick && (tcnt == SAMP_FIRST || tcnt == SAMP_MID)) begin
                samp <= {samp[0], rxs};
            end
            if (bidx_clr) begin
                bidx <= '0;
            end else if (shift_en) begin
                bidx <= bidx + 1'b1;
            end
            if (shift_en) begin
                shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            end
        end
    end

    // An ack in the same cycle as a completed byte frees the holding
    // register, so the new byte is taken and any old overrun is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= '0;
            avail_r <= 1'b0;
            ovr_r   <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            ferr_r <= ferr_set;
            if (byte_done) begin
                if (!avail_r || bus.rx_ack) begin
                    data_r  <= shreg;
                    avail_r <= 1'b1;
                    ovr_r   <= 1'b0;
                end else begin
                    ovr_r <= 1'b1;
                end
            end else if (bus.rx_ack && avail_r) begin
                avail_r <= 1'b0;
                ovr_r   <= 1'b0;
            end
        end
    end

    assign bus.rx_data      = data_r;
    assign bus.rx_avail     = avail_r;
    assign bus.rx_overrun   = ovr_r;
    assign bus.rx_frame_err = ferr_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Self-checking bench for uart_rx at 50 MHz / 115200 baud (432 cycles
// per bit). Frames are driven at the bit level; expectations come from
// a transaction-level model of the holding register (m_data, m_avail,
// m_ovr) and from queues of bytes that were sent.
module tb_uart_rx;

    localparam int BIT_CYC  = 432;
    localparam int TICK_CYC = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic ack = 1'b0;

    uart_rx_if bus ();
    assign bus.rx_ack = ack;

    uart_rx #(
        .clk_freq       (50000000),
        .uart_baud_rate (115200)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (rxd),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         cyc       = 0;
    int         fe_count  = 0;
    int         ovr_cyc   = 0;
    int         rise_cyc  = 0;
    int         got_n     = 0;
    logic       avail_d   = 1'b0;
    logic [7:0] got_mem [0:63];
    int         ack_req   = 0;
    int         ack_done  = 0;
    int         ack_at    = -1;
    bit         auto_ack  = 1'b0;
    int         start_cyc = 0;

    logic [7:0] m_data  = 8'h00;
    logic       m_avail = 1'b0;
    logic       m_ovr   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer side: counts pulses, timestamps rx_avail rising edges and
    // drives rx_ack (scheduled, on request, or automatically).
    always @(negedge clk) begin
        if (bus.rx_frame_err) fe_count <= fe_count + 1;
        if (bus.rx_overrun) ovr_cyc <= ovr_cyc + 1;
        avail_d <= bus.rx_avail;
        if (bus.rx_avail && !avail_d) rise_cyc <= cyc;
        if (ack) begin
            ack <= 1'b0;
        end else if (cyc == ack_at) begin
            ack <= 1'b1;
        end else if (ack_req != ack_done) begin
            ack      <= 1'b1;
            ack_done <= ack_done + 1;
        end else if (auto_ack && bus.rx_avail) begin
            got_mem[got_n[5:0]] <= bus.rx_data;
            got_n               <= got_n + 1;
            ack                 <= 1'b1;
        end
    end

    task automatic model_complete(input logic [7:0] b, input bit ack_same);
        if (!m_avail || ack_same) begin
            m_data  = b;
            m_avail = 1'b1;
            m_ovr   = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic model_ack();
        if (m_avail) begin
            m_avail = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    // Drives one 8N1 frame; the line is left at the stop-bit level.
    // Optionally inverts bit gbit for glen cycles starting goff into it.
    task automatic send_frame(input logic [7:0] b, input int p, input logic stop,
                              input int gbit, input int goff, input int glen);
        start_cyc = cyc;
        rxd = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            if (i == gbit) begin
                repeat (goff) @(negedge clk);
                rxd = ~b[i];
                repeat (glen) @(negedge clk);
                rxd = b[i];
                repeat (p - goff - glen) @(negedge clk);
            end else begin
                repeat (p) @(negedge clk);
            end
        end
        rxd = stop;
        repeat (p) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
        total++; if (bus.rx_avail !== 1'b0) begin bad++; $display("FAIL reset_avail: got %b want 0", bus.rx_avail); end
        total++; if (bus.rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", bus.rx_frame_err); end
        total++; if (bus.rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", bus.rx_overrun); end
        rst = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic test_single();
        int fe0;
        int lat;
        fe0 = fe_count;
        send_frame(8'hA5, BIT_CYC, 1'b1, -1, 0, 0);
        repeat (4) @(negedge clk);
        model_complete(8'hA5, 1'b0);
        lat = rise_cyc - start_cyc;
        total++; if (bus.rx_data !== m_data) begin bad++; $display("FAIL single_data: got %h want %h", bus.rx_data, m_data); end
        total++; if (bus.rx_avail !== m_avail) begin bad++; $display("FAIL single_avail: got %b want %b", bus.rx_avail, m_avail); end
        total++; if (lat < 4054 || lat > 4184) begin bad++; $display("FAIL single_latency: got %0d cycles want about 4104", lat); end
        total++; if (fe_count !== fe0) begin bad++; $display("FAIL single_ferr: got %0d pulses want 0", fe_count - fe0); end
        total++; if (bus.rx_overrun !== m_ovr) begin bad++; $display("FAIL single_ovr: got %b want %b", bus.rx_overrun, m_ovr); end
        ack_req++;
        repeat (2) @(negedge clk);
        model_ack();
        total++; if (bus.rx_avail !== m_avail) begin bad++; $display("FAIL single_ack_clear: got %b want %b", bus.rx_avail, m_avail); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        int n0, fe0, ov0;
        exp_q = '{8'h00, 8'hFF, 8'h55};
        n0 = got_n; fe0 = fe_count; ov0 = ovr_cyc;
        auto_ack = 1'b1;
        foreach (exp_q[i]) send_frame(exp_q[i], BIT_CYC, 1'b1, -1, 0, 0);
        repeat (20) @(negedge clk);
        auto_ack = 1'b0;
        total++; if (got_n - n0 != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got_n - n0, exp_q.size()); end
        foreach (exp_q[i]) begin
            total++; if (got_mem[(n0 + i) % 64] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_mem[(n0 + i) % 64], exp_q[i]); end
        end
        total++; if (fe_count !== fe0 || ovr_cyc !== ov0) begin bad++; $display("FAIL b2b_errors: got ferr=%0d ovr=%0d want 0", fe_count - fe0, ovr_cyc - ov0); end
    endtask

    task automatic test_overrun();
        int s1, d;
        send_frame(8'h3C, BIT_CYC, 1'b1, -1, 0, 0);
        s1 = start_cyc;
        repeat (4) @(negedge clk);
        d = rise_cyc - start_cyc;
        model_complete(8'h3C, 1'b0);
        send_frame(8'hC3, BIT_CYC, 1'b1, -1, 0, 0);
        repeat (4) @(negedge clk);
        model_complete(8'hC3, 1'b0);
        total++; if (bus.rx_data !== m_data) begin bad++; $display("FAIL ovr_data: got %h want %h", bus.rx_data, m_data); end
        total++; if (bus.rx_overrun !== m_ovr) begin bad++; $display("FAIL ovr_flag: got %b want %b", bus.rx_overrun, m_ovr); end
        // Same tick phase as the first frame, so the completion cycle is
        // known and the ack can be placed on it.
        for (int k = 0; k < TICK_CYC && ((cyc - s1) % TICK_CYC) != 0; k++) @(negedge clk);
        ack_at = cyc + d - 1;
        send_frame(8'h7E, BIT_CYC, 1'b1, -1, 0, 0);
        repeat (4) @(negedge clk);
        ack_at = -1;
        model_complete(8'h7E, 1'b1);
        total++; if (bus.rx_data !== m_data) begin bad++; $display("FAIL coinc_data: got %h want %h", bus.rx_data, m_data); end
        total++; if (bus.rx_avail !== m_avail) begin bad++; $display("FAIL coinc_avail: got %b want %b", bus.rx_avail, m_avail); end
        total++; if (bus.rx_overrun !== m_ovr) begin bad++; $display("FAIL coinc_ovr: got %b want %b", bus.rx_overrun, m_ovr); end
        send_frame(8'h11, BIT_CYC, 1'b1, -1, 0, 0);
        repeat (4) @(negedge clk);
        model_complete(8'h11, 1'b0);
        total++; if (bus.rx_overrun !== m_ovr || bus.rx_data !== m_data) begin bad++; $display("FAIL ovr2: got ovr=%b data=%h want ovr=%b data=%h", bus.rx_overrun, bus.rx_data, m_ovr, m_data); end
        ack_req++;
        repeat (3) @(negedge clk);
        model_ack();
        total++; if (bus.rx_avail !== m_avail) begin bad++; $display("FAIL ovr_ack_avail: got %b want %b", bus.rx_avail, m_avail); end
        total++; if (bus.rx_overrun !== m_ovr) begin bad++; $display("FAIL ovr_ack_flag: got %b want %b", bus.rx_overrun, m_ovr); end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_count;
        send_frame(8'h81, BIT_CYC, 1'b0, -1, 0, 0);
        repeat (20 * BIT_CYC) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        total++; if (fe_count - fe0 != 1) begin bad++; $display("FAIL ferr_pulses: got %0d want 1", fe_count - fe0); end
        total++; if (bus.rx_avail !== m_avail || bus.rx_data !== m_data) begin bad++; $display("FAIL ferr_hold: got avail=%b data=%h want avail=%b data=%h", bus.rx_avail, bus.rx_data, m_avail, m_data); end
        send_frame(8'h42, BIT_CYC, 1'b1, -1, 0, 0);
        repeat (4) @(negedge clk);
        model_complete(8'h42, 1'b0);
        total++; if (bus.rx_data !== m_data || bus.rx_avail !== m_avail) begin bad++; $display("FAIL ferr_recover: got avail=%b data=%h want avail=%b data=%h", bus.rx_avail, bus.rx_data, m_avail, m_data); end
        total++; if (fe_count - fe0 != 1) begin bad++; $display("FAIL ferr_recover_pulses: got %0d want 1", fe_count - fe0); end
        ack_req++;
        repeat (3) @(negedge clk);
        model_ack();
    endtask

    task automatic test_glitch();
        int fe0, r0;
        fe0 = fe_count; r0 = rise_cyc;
        rxd = 1'b0;
        repeat (3 * TICK_CYC) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        total++; if (rise_cyc !== r0 || bus.rx_avail !== m_avail) begin bad++; $display("FAIL glitch_no_rx: got avail=%b want %b", bus.rx_avail, m_avail); end
        total++; if (fe_count !== fe0) begin bad++; $display("FAIL glitch_ferr: got %0d pulses want 0", fe_count - fe0); end
        send_frame(8'hF0, BIT_CYC, 1'b1, 6, 203, TICK_CYC);
        repeat (4) @(negedge clk);
        model_complete(8'hF0, 1'b0);
        total++; if (bus.rx_data !== m_data || bus.rx_avail !== m_avail) begin bad++; $display("FAIL glitch_vote: got avail=%b data=%h want avail=%b data=%h", bus.rx_avail, bus.rx_data, m_avail, m_data); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h99;
        rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rxd = b[4];
        repeat (BIT_CYC / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", bus.rx_data); end
        total++; if (bus.rx_avail !== 1'b0) begin bad++; $display("FAIL rstmid_avail: got %b want 0", bus.rx_avail); end
        total++; if (bus.rx_overrun !== 1'b0 || bus.rx_frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_flags: got ovr=%b ferr=%b want 0", bus.rx_overrun, bus.rx_frame_err); end
        m_data = 8'h00; m_avail = 1'b0; m_ovr = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        rst = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        send_frame(8'h66, BIT_CYC, 1'b1, -1, 0, 0);
        repeat (4) @(negedge clk);
        model_complete(8'h66, 1'b0);
        total++; if (bus.rx_data !== m_data || bus.rx_avail !== m_avail) begin bad++; $display("FAIL rstmid_next: got avail=%b data=%h want avail=%b data=%h", bus.rx_avail, bus.rx_data, m_avail, m_data); end
        ack_req++;
        repeat (3) @(negedge clk);
        model_ack();
    endtask

    task automatic test_skew();
        logic [7:0] exp_q[$];
        int per_q[$];
        int n0, fe0, ov0;
        exp_q.push_back(8'hA5);
        per_q.push_back(421);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'($urandom));
            per_q.push_back($urandom_range(421, 443));
        end
        n0 = got_n; fe0 = fe_count; ov0 = ovr_cyc;
        auto_ack = 1'b1;
        foreach (exp_q[i]) begin
            send_frame(exp_q[i], per_q[i], 1'b1, -1, 0, 0);
            repeat ($urandom_range(0, 100)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        auto_ack = 1'b0;
        total++; if (got_n - n0 != exp_q.size()) begin bad++; $display("FAIL skew_count: got %0d want %0d", got_n - n0, exp_q.size()); end
        foreach (exp_q[i]) begin
            total++; if (got_mem[(n0 + i) % 64] !== exp_q[i]) begin bad++; $display("FAIL skew_byte%0d: got %h want %h (period %0d)", i, got_mem[(n0 + i) % 64], exp_q[i], per_q[i]); end
        end
        total++; if (fe_count !== fe0 || ovr_cyc !== ov0) begin bad++; $display("FAIL skew_errors: got ferr=%0d ovr=%0d want 0", fe_count - fe0, ovr_cyc - ov0); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_skew();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 frames in on the `system` UART RXD pin, bytes out to the system's internal command/LED logic.
- Sits directly downstream of the board pin that the system bench's comm partner drives.
- Oversamples 16x with majority vote; reports framing errors and overruns.
- Holds each byte until the consumer acknowledges it.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- uart_baud_rate, 115200, line rate in baud.
- Derived constant DIV = (clk_freq + 8*uart_baud_rate) / (16*uart_baud_rate), i.e. rounded. Elaboration must fail if DIV < 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- uart_rxd  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  8  last received byte.
- rx_avail  output  1  rx_data valid, held until acknowledged.
- rx_ack  input  1  consumer has taken rx_data; single-cycle strobe.
- rx_frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- rx_overrun  output  1  sticky: a byte was dropped because rx_avail was still set.

Behaviour:
- Clock and reset: single clock domain, clk only. Reset is asynchronous and active-high on rst. While rst=1:
  - rx_data=0x00, rx_avail=0, rx_frame_err=0, rx_overrun=0.
  - State IDLE, synchroniser flops set to 1.
- Input synchroniser: 2-FF on uart_rxd; all decisions use the synchronised value rxs. Input-to-decision latency is 2 cycles.
- Tick generator: free-running counter 0..DIV-1, emits tick for 1 cycle at DIV-1.
- Sample counter: tcnt, 4 bits, advances on tick only.
- IDLE:
  - rxs=0 → START, tcnt=0.
- START:
  - At tcnt=7, take the majority of rxs at ticks 6, 7, 8 (decision at tick 8).
  - Majority 0 → DATA, bit index=0.
  - Majority 1 → IDLE. A glitch is rejected with no output.
- DATA:
  - Every 16 ticks, majority sample at ticks 6/7/8 of the bit, shifted in LSB first.
  - After bit index 7 → STOP.
- STOP: majority sample at ticks 6/7/8.
  - Majority 1 (valid byte):
    - If rx_avail=0, or rx_ack=1 in the same cycle: rx_data←byte, rx_avail←1.
    - Otherwise the byte is dropped and rx_overrun←1.
    - Next state IDLE, entered immediately after the decision so back-to-back frames are caught.
  - Majority 0 (framing error):
    - rx_frame_err=1 for 1 cycle.
    - Byte discarded; rx_data and rx_avail unchanged.
    - Next state WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then IDLE. A line break therefore yields exactly one frame error.
- Ack handling:
  - rx_ack with rx_avail=1 clears rx_avail and rx_overrun in the next cycle.
  - rx_ack with rx_avail=0 is ignored.
  - Ack coincident with a byte completion: the new byte loads, rx_avail stays 1, rx_overrun is not set, and any previous overrun is cleared.
- Output latency: rx_avail rises 1 cycle after the stop-bit decision tick.
- Tolerance: start-edge detection error ≤1 tick, so total baud mismatch tolerance is about ±3%.
- Reset asserted mid-frame: immediate return to reset values; the partial byte is discarded.

Decomposition:
- Package uart_pkg, shared with the future uart_tx:
  - State encoding IDLE/START/DATA/STOP/WAIT_HIGH.
  - OVERSAMPLE=16, MID_TICK=7, DATA_BITS=8.
  - Function computing DIV from clk_freq and uart_baud_rate.
- Sub-module uart_baud_gen: parameterised DIV; outputs a tick strobe; reset to count 0; reused by uart_tx.

Test Plan:
- Setup: clk_freq=50000000, uart_baud_rate=115200, tck=20 ns → DIV=27, bit period 432 cycles.
- Scenario 1: send 0xA5 8N1 → rx_data=0xA5, rx_avail=1 about 9.5 bit times after the start edge; rx_frame_err and rx_overrun stay 0; rx_ack clears rx_avail next cycle.
- Scenario 2: send 0x00, 0xFF, 0x55 back-to-back, no idle gap, acking each within 100 cycles → all three received in order, no errors.
- Scenario 3: send 0x3C, no ack, then send 0xC3 → rx_data stays 0x3C, rx_overrun=1; rx_ack clears both rx_avail and rx_overrun.
- Scenario 4: 0x81 with stop bit forced low, then line held low for 20 bit times → exactly one rx_frame_err pulse, rx_avail=0; a following 0x42 is received cleanly.
- Scenario 5: low glitches of 3 ticks and of 1 cycle on an idle line → no reception, state returns to IDLE; a 1-tick low glitch inside a data bit of 0xF0 → still 0xF0 by majority vote.
- Scenario 6: assert rst at bit 4 of 0x99 → outputs at reset values immediately; the next frame 0x66 is received correctly. Also: sender at +2.5% baud, byte 0xA5 → received correctly.
